// File: rtl/cp0_unit.sv
// Coprocessor-0 for the pipelined MIPS core: SR, Cause, EPC and PRId registers,
// interrupt/exception arbitration against the M stage, mtc0/mfc0 access and eret.
module cp0_unit #(
    parameter logic [31:0] PRID = 32'h4255_4141
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  a1,
    input  logic [4:0]  a2,
    input  logic [31:0] din,
    input  logic        we,
    input  logic [31:0] pc,
    input  logic        bd,
    input  logic [4:0]  exccode_in,
    input  logic [5:0]  hwint,
    input  logic        exl_clr,
    output logic        intreq,
    output logic [31:0] epc,
    output logic [31:0] dout
);

    localparam logic [4:0] REG_SR    = 5'd12;
    localparam logic [4:0] REG_CAUSE = 5'd13;
    localparam logic [4:0] REG_EPC   = 5'd14;
    localparam logic [4:0] REG_PRID  = 5'd15;

    logic [5:0]  im_q,      im_d;
    logic        exl_q,     exl_d;
    logic        ie_q,      ie_d;
    logic        bd_q,      bd_d;
    logic [5:0]  ip_q,      ip_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [29:0] epc_q,     epc_d;

    logic        int_pend_s;
    logic        exc_pend_s;
    logic        intreq_s;
    logic        epc_wr_s;
    logic [29:0] victim_s;
    logic        unused_pc_s;

    // Only word-aligned return addresses are kept, so the PC byte offset is dropped.
    assign unused_pc_s = ^pc[1:0];
    assign victim_s    = bd ? (pc[31:2] - 30'd1) : pc[31:2];

    // Exception/interrupt arbitration; held off entirely while reset is asserted.
    assign int_pend_s = (|(hwint & im_q)) & ie_q & ~exl_q;
    assign exc_pend_s = (exccode_in != 5'd0) & ~exl_q;
    assign intreq_s   = (int_pend_s | exc_pend_s) & reset;
    assign intreq     = intreq_s;

    // Forward a same-cycle mtc0 EPC so eret right behind it returns to the new address.
    assign epc_wr_s = we & (a2 == REG_EPC);
    assign epc      = ~reset   ? 32'd0 :
                      epc_wr_s ? {din[31:2], 2'b00} :
                                 {epc_q, 2'b00};

    // mfc0 read mux; reflects state before the current edge.
    always_comb begin
        dout = 32'd0;
        case (a1)
            REG_SR:    dout = {16'd0, im_q, 8'd0, exl_q, ie_q};
            REG_CAUSE: dout = {bd_q, 15'd0, ip_q, 3'd0, exccode_q, 2'b00};
            REG_EPC:   dout = {epc_q, 2'b00};
            REG_PRID:  dout = PRID;
            default:   dout = 32'd0;
        endcase
    end

    // Next-state: exception entry beats eret, which beats mtc0.
    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        ip_d      = hwint;
        if (intreq_s) begin
            exl_d     = 1'b1;
            bd_d      = bd;
            epc_d     = victim_s;
            exccode_d = int_pend_s ? 5'd0 : exccode_in;
        end else begin
            if (we && (a2 == REG_SR)) begin
                im_d  = din[15:10];
                exl_d = din[1];
                ie_d  = din[0];
            end else begin
                im_d  = im_q;
            end
            if (epc_wr_s) begin
                epc_d = din[31:2];
            end else begin
                epc_d = epc_q;
            end
            // eret overrides any EXL value written by a concurrent mtc0.
            if (exl_clr) begin
                exl_d = 1'b0;
            end else begin
                exl_d = exl_d;
            end
        end
    end

    // CP0 state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q      <= 6'd0;
            exl_q     <= 1'b0;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= 6'd0;
            exccode_q <= 5'd0;
            epc_q     <= 30'd0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

endmodule
